// File: rtl/phv_axis_tx.sv
// PHV-to-AXI-Stream transmitter: buffers up to two PHVs and serializes each one
// as a fixed-length, tlast-terminated burst on a 512-bit AXIS master.
module phv_axis_tx #(
   parameter int C_AXIS_DATA_WIDTH  = 512,
   parameter int C_AXIS_TUSER_WIDTH = 128,
   parameter int C_PKT_VEC_WIDTH    = 1124
) (
   input  logic                              clk,
   input  logic                              aresetn,
   input  logic [C_PKT_VEC_WIDTH-1:0]        phv_in,
   input  logic                              phv_in_valid,
   output logic                              phv_in_ready,
   output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
   output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic                              m_axis_tlast,
   output logic [31:0]                       phv_drop_cnt
);

   localparam int BEATS      = (C_PKT_VEC_WIDTH + C_AXIS_DATA_WIDTH - 1) / C_AXIS_DATA_WIDTH;
   localparam int LAST_BITS  = C_PKT_VEC_WIDTH - (BEATS - 1) * C_AXIS_DATA_WIDTH;
   localparam int LAST_BYTES = (LAST_BITS + 7) / 8;
   localparam int KEEP_W     = C_AXIS_DATA_WIDTH / 8;
   localparam int PAD_W      = BEATS * C_AXIS_DATA_WIDTH;

   localparam logic [1:0]        LAST_BEAT = 2'(BEATS - 1);
   localparam logic [KEEP_W-1:0] KEEP_FULL = '1;
   localparam logic [KEEP_W-1:0] KEEP_LAST = KEEP_FULL >> (KEEP_W - LAST_BYTES);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                     state;
   logic [C_PKT_VEC_WIDTH-1:0] buf_phv [2];
   logic [15:0]                buf_seq [2];
   logic                       head;
   logic                       tail;
   logic [1:0]                 count;
   logic [1:0]                 count_nxt;
   logic [1:0]                 beat;
   logic [15:0]                seq;
   logic [31:0]                drop_cnt;
   logic                       beat_fire;
   logic                       pop;
   logic                       wr_en;
   logic [PAD_W-1:0]           phv_pad;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // A full buffer still accepts a write when the head leaves on this same edge.
   assign beat_fire = (state == SEND) & m_axis_tready;
   assign pop       = beat_fire & (beat == LAST_BEAT);
   assign wr_en     = phv_in_valid & ((count != 2'd2) | pop);

   always_comb begin
      count_nxt = count + {1'b0, wr_en} - {1'b0, pop};
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         buf_phv[tail] <= phv_in;
         buf_seq[tail] <= seq;
      end
   end

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         state    <= IDLE;
         head     <= 1'b0;
         tail     <= 1'b0;
         count    <= 2'd0;
         beat     <= 2'd0;
         seq      <= 16'd0;
         drop_cnt <= 32'd0;
      end else begin
         count <= count_nxt;
         state <= (count_nxt != 2'd0) ? SEND : IDLE;
         if (wr_en) begin
            tail <= ~tail;
            seq  <= seq + 16'd1;
         end else if (phv_in_valid) begin
            drop_cnt <= sat_inc(drop_cnt);
         end
         if (pop) begin
            head <= ~head;
         end
         if (beat_fire) begin
            beat <= pop ? 2'd0 : beat + 2'd1;
         end
      end
   end

   // Beat mux over the zero-padded head entry; everything is forced to zero while idle.
   always_comb begin
      phv_pad                        = '0;
      phv_pad[C_PKT_VEC_WIDTH-1:0]   = buf_phv[head];
      m_axis_tdata                   = '0;
      m_axis_tkeep                   = '0;
      m_axis_tuser                   = '0;
      if (state == SEND) begin
         m_axis_tdata        = phv_pad[int'(beat) * C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
         m_axis_tkeep        = (beat == LAST_BEAT) ? KEEP_LAST : KEEP_FULL;
         m_axis_tuser[15:0]  = buf_seq[head];
         m_axis_tuser[17:16] = beat;
      end
   end

   assign m_axis_tvalid = (state == SEND);
   assign m_axis_tlast  = (state == SEND) & (beat == LAST_BEAT);
   assign phv_in_ready  = (count != 2'd2);
   assign phv_drop_cnt  = drop_cnt;

endmodule
